noc_traffic_gen: RTL and testbench
==================================

Name: noc_traffic_gen

Overview:
- Parametrised, self-timed traffic source for the spidergon NoC; replaces static per-node reset-time flit injection.
- Emits multi-flit packets (head/body/tail or single header flit) on every active node, selected by a runtime mode.
- Uses a per-node valid/ready handshake so router backpressure is honoured; VC alternates per packet.
- Reports completion and a total flit count.

Parameters:
- NUM_OF_NODES, 8, node count (≥4, power of two).
- FLIT_DATA_WIDTH, 16, payload width.
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs per input port (≥2, power of two).
- PACKET_LENGTH, 4, flits per packet including head and tail (≥1).
- NUM_OF_PACKETS, 4, packets per active node per run (≥1).
- INJECTION_GAP, 2, idle cycles between a tail handshake and the next head (0 allowed).
- Derived: VW=$clog2(NUM_OF_VIRTUAL_CHANNELS), DW=$clog2(NUM_OF_NODES), FLIT_TOTAL_WIDTH=2+VW+FLIT_DATA_WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle run request; ignored while busy.
- mode  input  2  0: node1→0; 1: nodes 1,2→0; 2: nodes 1,2,N-2,N-1→0; 3: every node i→(i+1) mod N.
- flit_ready  input  NUM_OF_NODES  per-node accept from router.
- flit_valid  output  NUM_OF_NODES  per-node flit valid.
- flit_data  output  NUM_OF_NODES*FLIT_TOTAL_WIDTH  node i at [i*FLIT_TOTAL_WIDTH +: FLIT_TOTAL_WIDTH].
- busy  output  1  run in progress.
- done  output  1  run complete; level signal.
- flits_sent  output  16  total handshaken flits this run; saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0, every node FSM → IDLE, mode latch cleared. Reset mid-run aborts immediately; no partial packet is completed.
- Flit layout: [top 2 bits]=type, next VW bits=VC, low FLIT_DATA_WIDTH=data. Types: HEAD=01, BODY=10, TAIL=00, HEADER (single-flit)=11.
- Head/HEADER data: {dest[DW], src[DW], zeros}. Body/tail data: {src[DW], seq[FLIT_DATA_WIDTH-DW]}. seq is the node's flit index since start (head of packet 0 = 0), wrapping modulo width.
- VC of packet k = k mod NUM_OF_VIRTUAL_CHANNELS. Constant across all flits of that packet.
- PACKET_LENGTH==1: one HEADER flit. ==2: HEAD then TAIL. >2: HEAD, PACKET_LENGTH-2 BODY, TAIL.
- Start: with start=1 and busy=0 at edge t, latch mode, clear flits_sent and done, set busy. Active nodes present the head at t+1.
- Inactive nodes keep flit_valid=0 and flit_data=0 for the whole run.
- Per-node FSM: IDLE→HEAD→BODY→TAIL→(GAP or HEAD or FIN); HEADER→(GAP or HEAD or FIN).
  - Advance only on valid&&ready.
  - GAP holds valid=0 for exactly INJECTION_GAP cycles, then HEAD. INJECTION_GAP=0 skips GAP, giving back-to-back packets.
  - FIN is entered after the tail of packet NUM_OF_PACKETS-1.
- Handshake: valid never drops and data never changes while valid&&!ready. With ready held high, flits of a packet issue on consecutive cycles.
- flits_sent increments by popcount(flit_valid & flit_ready) each cycle. Simultaneous handshakes on all nodes are counted in one cycle.
- Completion: in the cycle after the last active node enters FIN, busy→0 and done→1. All FSMs return to IDLE and done holds until the next accepted start or reset.
- start asserted while busy=1 is ignored, with no effect on counters or mode. start during done=1 begins a new run.
- mode changes during a run have no effect.

Test Plan:
- Defaults, mode=0, ready all 1, pulse start at cycle 10 → node1 valid cycles 11–14, flit_data[1] types 01,10,10,00, head data {3'd0,3'd1,10'd0}, VC 0. Gap at 15–16, packet 1 with VC 1 at 17–20. done=1 and flits_sent=16 after the last tail.
- mode=3, ready all 1 → each node i sends head with dest (i+1) mod 8 (node 7→0) in the same cycle. flits_sent increments by 8 per cycle during bursts; final flits_sent=128.
- mode=1, flit_ready[1] toggled 0/1 every cycle → node1 flit_data and valid stable during every ready=0 cycle. Node2 unaffected. done only after node1's 4th tail.
- PACKET_LENGTH=1, INJECTION_GAP=0, mode=2 → nodes 1,2,6,7 emit type 11 flits every cycle for 4 cycles, VC sequence 0,1,0,1. flits_sent=16.
- Reset (reset=0) asserted mid-body, mode=0 → next cycle flit_valid=0, busy=0, done=0, flits_sent=0. A new start restarts at packet 0 with seq 0.
- start pulsed again while busy, and mode changed mid-run → trace identical to an undisturbed run.

Source files
------------

// File: rtl/noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : noc_traffic_gen
// Brief    : Self-timed multi-flit packet source for the spidergon NoC with
//            per-node valid/ready handshake, per-packet VC alternation and a
//            saturating handshaken-flit counter.
// Revision : 1.0
// ============================================================================
module noc_traffic_gen #(
    parameter int NUM_OF_NODES            = 8,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int PACKET_LENGTH           = 4,
    parameter int NUM_OF_PACKETS          = 4,
    parameter int INJECTION_GAP           = 2,
    localparam int VW                     = $clog2(NUM_OF_VIRTUAL_CHANNELS),
    localparam int DW                     = $clog2(NUM_OF_NODES),
    localparam int FLIT_TOTAL_WIDTH       = 2 + VW + FLIT_DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [1:0]                             mode,
    input  logic [NUM_OF_NODES-1:0]                flit_ready,
    output logic [NUM_OF_NODES-1:0]                flit_valid,
    output logic [NUM_OF_NODES*FLIT_TOTAL_WIDTH-1:0] flit_data,
    output logic                                   busy,
    output logic                                   done,
    output logic [15:0]                            flits_sent
);

    localparam int         c_SW         = FLIT_DATA_WIDTH - DW;
    localparam int         c_PADW       = FLIT_DATA_WIDTH - 2 * DW;
    localparam int         c_CW         = $clog2(NUM_OF_NODES + 1);
    localparam logic [1:0] c_T_HEAD     = 2'b01;
    localparam logic [1:0] c_T_BODY     = 2'b10;
    localparam logic [1:0] c_T_TAIL     = 2'b00;
    localparam logic [1:0] c_T_HDR      = 2'b11;
    localparam logic [1:0] c_FIRST_TYPE = (PACKET_LENGTH == 1) ? c_T_HDR : c_T_HEAD;
    localparam logic [31:0] c_LAST_BEAT = 32'(PACKET_LENGTH - 1);
    localparam logic [31:0] c_LAST_PKT  = 32'(NUM_OF_PACKETS - 1);
    localparam logic [31:0] c_GAP_LOAD  = 32'((INJECTION_GAP > 0) ? INJECTION_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEAD   = 3'd1,
        S_BODY   = 3'd2,
        S_TAIL   = 3'd3,
        S_HEADER = 3'd4,
        S_GAP    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    localparam state_t c_FIRST_STATE = (PACKET_LENGTH == 1) ? S_HEADER : S_HEAD;

    function automatic logic [NUM_OF_NODES-1:0] f_active(input logic [1:0] m);
        logic [NUM_OF_NODES-1:0] v;
        v = '0;
        case (m)
            2'd0: v[1] = 1'b1;
            2'd1: begin
                v[1] = 1'b1;
                v[2] = 1'b1;
            end
            2'd2: begin
                v[1]              = 1'b1;
                v[2]              = 1'b1;
                v[NUM_OF_NODES-2] = 1'b1;
                v[NUM_OF_NODES-1] = 1'b1;
            end
            default: v = '1;
        endcase
        return v;
    endfunction

    function automatic logic [FLIT_TOTAL_WIDTH-1:0] f_head(input logic [VW-1:0] vc,
                                                           input logic [DW-1:0] dest,
                                                           input logic [DW-1:0] src);
        return {c_FIRST_TYPE, vc, dest, src, {c_PADW{1'b0}}};
    endfunction

    function automatic logic [FLIT_TOTAL_WIDTH-1:0] f_body(input logic [1:0]      t,
                                                           input logic [VW-1:0]   vc,
                                                           input logic [DW-1:0]   src,
                                                           input logic [c_SW-1:0] seq);
        return {t, vc, src, seq};
    endfunction

    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_cnt;
    logic [1:0]              r_mode;
    logic                    w_start_acc;
    logic [1:0]              w_mode_sel;
    logic [NUM_OF_NODES-1:0] w_active;
    logic [NUM_OF_NODES-1:0] w_fin;
    logic                    w_all_fin;
    logic [c_CW-1:0]         w_hs_cnt;
    logic [16:0]             w_cnt_sum;

    assign w_start_acc = start && !r_busy;
    // The start edge must already see the incoming mode; afterwards only the latch counts.
    assign w_mode_sel  = r_busy ? r_mode : mode;
    assign w_active    = f_active(w_mode_sel);
    assign w_all_fin   = &w_fin;
    assign w_cnt_sum   = {1'b0, r_cnt} + 17'(w_hs_cnt);

    always_comb begin
        w_hs_cnt = '0;
        for (int k = 0; k < NUM_OF_NODES; k++) begin
            w_hs_cnt = w_hs_cnt + c_CW'(flit_valid[k] & flit_ready[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_mode <= '0;
        end else if (w_start_acc) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_mode <= mode;
        end else begin
            if (r_busy && w_all_fin) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            r_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign flits_sent = r_cnt;

    for (genvar gi = 0; gi < NUM_OF_NODES; gi++) begin : g_node
        localparam logic [DW-1:0] c_SRC  = DW'(gi);
        localparam logic [DW-1:0] c_NEXT = DW'((gi + 1) % NUM_OF_NODES);

        state_t                      r_state;
        logic                        r_valid;
        logic [FLIT_TOTAL_WIDTH-1:0] r_data;
        logic [31:0]                 r_pkt;
        logic [31:0]                 r_beat;
        logic [31:0]                 r_gap;
        logic [c_SW-1:0]             r_seq;
        logic [DW-1:0]               w_dest;
        logic                        w_hs;
        logic [c_SW-1:0]             w_seq_nxt;
        logic [31:0]                 w_beat_nxt;
        logic [31:0]                 w_pkt_nxt;

        assign w_dest     = (w_mode_sel == 2'd3) ? c_NEXT : '0;
        assign w_hs       = r_valid & flit_ready[gi];
        assign w_seq_nxt  = r_seq + 1'b1;
        assign w_beat_nxt = r_beat + 32'd1;
        assign w_pkt_nxt  = r_pkt + 32'd1;
        assign w_fin[gi]  = (r_state == S_FIN) || !w_active[gi];

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_data  <= '0;
                r_pkt   <= '0;
                r_beat  <= '0;
                r_gap   <= '0;
                r_seq   <= '0;
            end else if (w_start_acc) begin
                r_pkt  <= '0;
                r_beat <= '0;
                r_gap  <= '0;
                r_seq  <= '0;
                if (w_active[gi]) begin
                    r_state <= c_FIRST_STATE;
                    r_valid <= 1'b1;
                    r_data  <= f_head('0, w_dest, c_SRC);
                end else begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end
            end else if (r_busy && w_all_fin) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_HEAD, S_BODY, S_TAIL, S_HEADER: begin
                        // Everything holds until the router accepts the current flit.
                        if (w_hs) begin
                            r_seq <= w_seq_nxt;
                            if (r_state == S_TAIL || r_state == S_HEADER) begin
                                r_beat <= '0;
                                if (r_pkt == c_LAST_PKT) begin
                                    r_state <= S_FIN;
                                    r_valid <= 1'b0;
                                    r_data  <= '0;
                                end else begin
                                    r_pkt <= w_pkt_nxt;
                                    if (INJECTION_GAP == 0) begin
                                        r_state <= c_FIRST_STATE;
                                        r_data  <= f_head(w_pkt_nxt[VW-1:0], w_dest, c_SRC);
                                    end else begin
                                        r_state <= S_GAP;
                                        r_valid <= 1'b0;
                                        r_data  <= '0;
                                        r_gap   <= c_GAP_LOAD;
                                    end
                                end
                            end else begin
                                r_beat  <= w_beat_nxt;
                                r_state <= (w_beat_nxt == c_LAST_BEAT) ? S_TAIL : S_BODY;
                                r_data  <= f_body((w_beat_nxt == c_LAST_BEAT) ? c_T_TAIL : c_T_BODY,
                                                  r_pkt[VW-1:0], c_SRC, w_seq_nxt);
                            end
                        end
                    end
                    S_GAP: begin
                        if (r_gap == 32'd0) begin
                            r_state <= c_FIRST_STATE;
                            r_valid <= 1'b1;
                            r_data  <= f_head(r_pkt[VW-1:0], w_dest, c_SRC);
                        end else begin
                            r_gap <= r_gap - 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign flit_valid[gi] = r_valid;
        assign flit_data[gi*FLIT_TOTAL_WIDTH +: FLIT_TOTAL_WIDTH] = r_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_traffic_gen
// Brief    : Directed self-checking bench for noc_traffic_gen (default build
//            plus a single-flit, zero-gap build).
// Revision : 1.0
// ============================================================================
module tb_noc_traffic_gen;

    localparam int N   = 8;
    localparam int FTW = 19;

    logic             clk;
    logic             reset;
    logic             start;
    logic             start1;
    logic [1:0]       mode;
    logic [N-1:0]     ready;
    logic [N-1:0]     ready1;
    logic [N-1:0]     valid;
    logic [N-1:0]     valid1;
    logic [N*FTW-1:0] data;
    logic [N*FTW-1:0] data1;
    logic             busy;
    logic             done;
    logic             busy1;
    logic             done1;
    logic [15:0]      sent;
    logic [15:0]      sent1;

    int n_tests = 0;
    int n_fail  = 0;

    noc_traffic_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .flit_ready (ready),
        .flit_valid (valid),
        .flit_data  (data),
        .busy       (busy),
        .done       (done),
        .flits_sent (sent)
    );

    noc_traffic_gen #(
        .PACKET_LENGTH (1),
        .INJECTION_GAP (0)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .mode       (mode),
        .flit_ready (ready1),
        .flit_valid (valid1),
        .flit_data  (data1),
        .busy       (busy1),
        .done       (done1),
        .flits_sent (sent1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FTW-1:0] flit_of(input logic [N*FTW-1:0] bus, input int i);
        return bus[i*FTW +: FTW];
    endfunction

    // Expected flit f (count since start) of a node in the default 4-flit build.
    function automatic logic [FTW-1:0] exp_flit(input int src, input int dest, input int f);
        int         pkt;
        int         beat;
        logic [1:0] t;
        logic [15:0] d;
        pkt  = f / 4;
        beat = f % 4;
        t    = (beat == 0) ? 2'b01 : ((beat == 3) ? 2'b00 : 2'b10);
        if (beat == 0) d = {3'(dest), 3'(src), 10'd0};
        else           d = {3'(src), 13'(f)};
        return {t, 1'(pkt % 2), d};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic run_mode0(input bit disturb);
        bit vexp;
        int f;
        ready = '1;
        mode  = 2'd0;
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            vexp = ((c - 1) % 6 < 4) && (c <= 22);
            f    = 4 * ((c - 1) / 6) + ((c - 1) % 6);
            check("m0 valid", 32'(valid), vexp ? 32'h2 : 32'h0);
            if (vexp) check("m0 flit", 32'(flit_of(data, 1)), 32'(exp_flit(1, 0, f)));
            if (c == 1)  check("m0 head pkt0", 32'(flit_of(data, 1)), 32'h20400);
            if (c == 2)  check("m0 body seq1", 32'(flit_of(data, 1)), 32'h42001);
            if (c == 4)  check("m0 tail pkt0", 32'(flit_of(data, 1)), 32'h02003);
            if (c == 7)  check("m0 head pkt1", 32'(flit_of(data, 1)), 32'h30400);
            if (c == 10) check("m0 tail pkt1", 32'(flit_of(data, 1)), 32'h12007);
            if (c == 5)  check("m0 sent mid", 32'(sent), 32'd4);
            if (c == 5)  check("m0 node0 data", 32'(flit_of(data, 0)), 32'd0);
            if (c == 23) check("m0 busy before done", {30'd0, busy, done}, 32'h2);
            if (c == 24) check("m0 done", {30'd0, busy, done}, 32'h1);
            if (c == 24) check("m0 sent final", 32'(sent), 32'd16);
            if (disturb && c == 3) begin
                start = 1'b1;
                mode  = 2'd3;
            end
            if (disturb && c == 4) start = 1'b0;
            @(negedge clk);
        end
        check("m0 done hold", 32'(done), 32'd1);
    endtask

    initial begin
        bit stalled;
        int f1;
        int f2;
        reset  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        mode   = 2'd0;
        ready  = '1;
        ready1 = '1;
        repeat (3) @(negedge clk);
        check("rst valid", 32'(valid), 32'd0);
        check("rst data", 32'(data[31:0]), 32'd0);
        check("rst busy/done", {30'd0, busy, done}, 32'd0);
        check("rst sent", 32'(sent), 32'd0);
        reset = 1'b1;
        repeat (9) @(negedge clk);

        run_mode0(1'b0);
        run_mode0(1'b1);

        // Ring mode: every node injects towards its successor.
        ready = '1;
        mode  = 2'd3;
        pulse_start();
        check("m3 valid", 32'(valid), 32'hFF);
        for (int i = 0; i < N; i++) begin
            check("m3 head", 32'(flit_of(data, i)), {13'd0, 2'b01, 1'b0, 3'((i + 1) % N), 3'(i), 10'd0});
        end
        @(negedge clk);
        check("m3 sent c2", 32'(sent), 32'd8);
        @(negedge clk);
        check("m3 sent c3", 32'(sent), 32'd16);
        wait_done("m3 done timeout", 60);
        check("m3 sent final", 32'(sent), 32'd128);

        // Backpressure on node 1 only.
        ready   = '1;
        mode    = 2'd1;
        pulse_start();
        stalled = 1'b0;
        f1      = 0;
        f2      = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (stalled) check("m1 hold valid", 32'(valid[1]), 32'd1);
            if (valid[1]) check("m1 n1 flit", 32'(flit_of(data, 1)), 32'(exp_flit(1, 0, f1)));
            if (valid[2]) check("m1 n2 flit", 32'(flit_of(data, 2)), 32'(exp_flit(2, 0, f2)));
            ready[1] = (c % 2 == 1);
            stalled  = valid[1] && !ready[1];
            if (valid[1] && ready[1]) f1++;
            if (valid[2]) f2++;
            @(negedge clk);
        end
        check("m1 done", 32'(done), 32'd1);
        check("m1 n1 flits at done", 32'(f1), 32'd16);
        check("m1 n2 flits", 32'(f2), 32'd16);
        check("m1 sent", 32'(sent), 32'd32);
        ready = '1;

        // Single-flit packets, no gap, four-node mode.
        mode   = 2'd2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                check("p1 valid", 32'(valid1), 32'hC6);
                for (int i = 1; i < N; i++) begin
                    if (i == 1 || i == 2 || i == 6 || i == 7)
                        check("p1 flit", 32'(flit_of(data1, i)),
                              {13'd0, 2'b11, 1'((c - 1) % 2), 3'd0, 3'(i), 10'd0});
                end
            end
            if (c == 5) check("p1 idle", 32'(valid1), 32'd0);
            if (c == 6) check("p1 done", {30'd0, busy1, done1}, 32'h1);
            if (c == 6) check("p1 sent", 32'(sent1), 32'd16);
            @(negedge clk);
        end

        // Reset in the middle of the first body flit.
        mode = 2'd0;
        pulse_start();
        @(negedge clk);
        check("rs body before", 32'(flit_of(data, 1)), 32'h42001);
        reset = 1'b0;
        @(negedge clk);
        check("rs valid", 32'(valid), 32'd0);
        check("rs busy/done", {30'd0, busy, done}, 32'd0);
        check("rs sent", 32'(sent), 32'd0);
        reset = 1'b1;
        pulse_start();
        check("rs restart head", 32'(flit_of(data, 1)), 32'h20400);
        @(negedge clk);
        check("rs restart body", 32'(flit_of(data, 1)), 32'h42001);
        wait_done("rs done timeout", 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
